// File: rtl/itch_msg_sequencer_if.sv
// Byte-stream bus between the ITCH byte source and the framing controller,
// plus the framed, registered outputs consumed by the decoder bank.
interface itch_msg_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [7:0]       byte_in;
    logic             valid_in;
    logic [7:0]       byte_out;
    logic             valid_out;
    logic [5:0]       byte_idx;
    logic [5:0]       dec_sel;
    logic             sof;
    logic             eof;
    logic             msg_done;
    logic             unk_type;
    logic             abort;
    logic [CNT_W-1:0] msg_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output byte_in, valid_in,
        input  byte_out, valid_out, byte_idx, dec_sel, sof, eof,
               msg_done, unk_type, abort, msg_count, err_count
    );

    modport slave (
        input  byte_in, valid_in,
        output byte_out, valid_out, byte_idx, dec_sel, sof, eof,
               msg_done, unk_type, abort, msg_count, err_count
    );
endinterface

// File: rtl/itch_msg_sequencer.sv
// ITCH framing controller: finds message boundaries from the type-length table
// and forwards each byte one cycle later with decoder select and framing strobes.
module itch_msg_sequencer #(
    parameter int GAP_MAX = 4,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst,
    itch_msg_sequencer_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_BODY, S_SKIP} state_t;

    state_t           state_q, state_d;
    logic [5:0]       rem_q, rem_d;
    logic [3:0]       gap_q, gap_d;
    logic [5:0]       idx_q, idx_d;
    logic [5:0]       sel_q, sel_d;
    logic             sof_d, eof_d, done_d, unk_d, abort_d;
    logic             sof_q, eof_q, done_q, unk_q, abort_q;
    logic [7:0]       byte_q;
    logic             valid_q;
    logic [CNT_W-1:0] msg_q, err_q;

    logic [5:0] typ_len;
    logic [5:0] typ_sel;
    logic       typ_known;
    logic [3:0] gap_inc;
    logic       gap_hit;
    logic       last_byte;

    // Type byte lookup: message length and one-hot decoder select.
    always_comb begin
        typ_len = 6'd2;
        typ_sel = 6'b000000;
        case (bus.byte_in)
            8'h41: begin typ_len = 6'd36; typ_sel = 6'b000001; end // 'A'
            8'h58: begin typ_len = 6'd23; typ_sel = 6'b000010; end // 'X'
            8'h55: begin typ_len = 6'd27; typ_sel = 6'b000100; end // 'U'
            8'h44: begin typ_len = 6'd9;  typ_sel = 6'b001000; end // 'D'
            8'h45: begin typ_len = 6'd30; typ_sel = 6'b010000; end // 'E'
            8'h50: begin typ_len = 6'd40; typ_sel = 6'b100000; end // 'P'
            default: ;
        endcase
    end

    assign typ_known = |typ_sel;
    assign gap_inc   = gap_q + 4'd1;
    assign gap_hit   = (gap_inc == 4'(GAP_MAX));
    assign last_byte = (rem_q == 6'd1);

    // NOTE: state and datapath registers use non-blocking assignments so every
    // register samples pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.valid_in) state_d = typ_known ? S_BODY : S_SKIP;
            S_BODY, S_SKIP: begin
                if (bus.valid_in) begin
                    if (last_byte) state_d = S_IDLE;
                end else if (gap_hit) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        rem_d   = rem_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        sof_d   = 1'b0;
        eof_d   = 1'b0;
        done_d  = 1'b0;
        unk_d   = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                gap_d = 4'd0;
                sel_d = 6'b000000;
                if (bus.valid_in) begin
                    rem_d = typ_len - 6'd1;
                    idx_d = 6'd0;
                    sel_d = typ_sel;
                    sof_d = 1'b1;
                    unk_d = ~typ_known;
                end
            end
            S_BODY, S_SKIP: begin
                if (bus.valid_in) begin
                    idx_d = idx_q + 6'd1;
                    rem_d = rem_q - 6'd1;
                    gap_d = 4'd0;
                    if (last_byte) begin
                        eof_d  = 1'b1;
                        done_d = (state_q == S_BODY);
                    end
                end else if (gap_hit) begin
                    // Stalled too long: drop the message and release the decoders.
                    gap_d   = 4'd0;
                    abort_d = 1'b1;
                    sel_d   = 6'b000000;
                end else begin
                    gap_d = gap_inc;
                end
            end
            default: begin
                gap_d = 4'd0;
                sel_d = 6'b000000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
            unk_q   <= 1'b0;
            abort_q <= 1'b0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            msg_q   <= '0;
            err_q   <= '0;
        end else begin
            rem_q   <= rem_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
            unk_q   <= unk_d;
            abort_q <= abort_d;
            byte_q  <= bus.byte_in;
            valid_q <= bus.valid_in;
            if (done_d && (msg_q != '1))
                msg_q <= msg_q + 1'b1;
            // Abort and unknown type never coincide; OR keeps the step at +1 anyway.
            if ((unk_d || abort_d) && (err_q != '1))
                err_q <= err_q + 1'b1;
        end
    end

    assign bus.byte_out  = byte_q;
    assign bus.valid_out = valid_q;
    assign bus.byte_idx  = idx_q;
    assign bus.dec_sel   = sel_q;
    assign bus.sof       = sof_q;
    assign bus.eof       = eof_q;
    assign bus.msg_done  = done_q;
    assign bus.unk_type  = unk_q;
    assign bus.abort     = abort_q;
    assign bus.msg_count = msg_q;
    assign bus.err_count = err_q;
endmodule
